// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the memory-op classifier
// used by the pipelined data memory stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } mstate_t;

  typedef struct packed {
    logic is_read;
    logic is_write;
    logic addr_from_vala;
  } mem_cls_t;

  function automatic mem_cls_t classify(
    input logic [3:0] icode
  );
    mem_cls_t c;
    c = '0;
    unique case (1'b1)
      (icode == IMRMOVQ): c.is_read = 1'b1;
      (icode == IPOPQ),
      (icode == IRET): begin
        c.is_read = 1'b1;
        c.addr_from_vala = 1'b1;
      end
      (icode == IRMMOVQ),
      (icode == IPUSHQ),
      (icode == ICALL): c.is_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_data_memory_dmem_array.sv
// Single-port synchronous RAM with registered read;
// contents are never cleared by reset.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata <= '0;
    else if (en && !we)
      rdata <= mem[idx];
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Y86-64 memory stage: byte-addressed, alignment-checked,
// multi-cycle access with a busy handshake to the stall logic.
module pipelined_data_memory
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8192,
  parameter int MEM_LAT     = 2,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic [2:0]        m_stat,
  output logic [3:0]        m_icode,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic              m_busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] LIMIT =
    DATA_W'(DEPTH) << 3;

  mem_cls_t          cls;
  logic [DATA_W-1:0] addr;
  logic              addr_err;
  logic              rw;
  logic              mem_op;
  logic              commit;
  logic [DATA_W-1:0] rdata;
  mstate_t           state;
  logic [3:0]        cnt;
  logic              unused_cnd;

  assign unused_cnd = M_Cnd;

  assign cls  = classify(M_icode);
  assign rw   = cls.is_read | cls.is_write;
  assign addr = cls.addr_from_vala ? M_valA : M_valE;

  assign addr_err = (addr >= LIMIT) ||
    ((ALIGN_CHECK != 0) && (addr[2:0] != 3'b000));

  assign mem_op = rw && (M_stat == SAOK) && !addr_err;

  always_comb begin
    m_stat = M_stat;
    if (M_stat == SAOK && rw && addr_err)
      m_stat = SADR;
  end

  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstE  = M_dstE;
  assign m_dstM  = M_dstM;

  // The first busy cycle is the IDLE cycle the op arrives in,
  // so ACCESS only needs MEM_LAT-1 further cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (MEM_LAT == 1) begin
              state <= S_DONE;
            end else begin
              state <= S_ACCESS;
              cnt   <= 4'(MEM_LAT - 2);
            end
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0)
            state <= S_DONE;
          else
            cnt <= cnt - 4'd1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign commit = rst_n && mem_op && (
    ((state == S_ACCESS) && (cnt == 4'd0)) ||
    ((state == S_IDLE) && (MEM_LAT == 1)));

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (commit),
    .we   (cls.is_write),
    .idx  (addr[IW+2:3]),
    .wdata(M_valA),
    .rdata(rdata)
  );

  assign m_busy = rst_n && (
    ((state == S_IDLE) && mem_op) ||
    (state == S_ACCESS));

  assign m_valM =
    (rst_n && (state == S_DONE) && mem_op && cls.is_read)
      ? rdata : '0;

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Bench for pipelined_data_memory: table-driven ops with a
// per-cycle scoreboard, plus reset and latency corner cases.
module tb_pipelined_data_memory;
  import y86_pkg::*;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  M_stat  [2];
  logic [3:0]  M_icode [2];
  logic [63:0] M_valE  [2];
  logic [63:0] M_valA  [2];
  logic        M_Cnd;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  logic [2:0]  m_stat  [2];
  logic [3:0]  m_icode [2];
  logic [63:0] m_valE  [2];
  logic [63:0] m_valM  [2];
  logic [3:0]  m_dstE  [2];
  logic [3:0]  m_dstM  [2];
  logic        m_busy  [2];

  pipelined_data_memory #(
    .MEM_LAT(LAT0), .ALIGN_CHECK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat[0]), .M_icode(M_icode[0]),
    .M_Cnd(M_Cnd), .M_valE(M_valE[0]),
    .M_valA(M_valA[0]), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .m_stat(m_stat[0]),
    .m_icode(m_icode[0]), .m_valE(m_valE[0]),
    .m_valM(m_valM[0]), .m_dstE(m_dstE[0]),
    .m_dstM(m_dstM[0]), .m_busy(m_busy[0])
  );

  pipelined_data_memory #(
    .MEM_LAT(LAT1), .ALIGN_CHECK(0)
  ) dut_na (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat[1]), .M_icode(M_icode[1]),
    .M_Cnd(M_Cnd), .M_valE(M_valE[1]),
    .M_valA(M_valA[1]), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .m_stat(m_stat[1]),
    .m_icode(m_icode[1]), .m_valE(m_valE[1]),
    .m_valM(m_valM[1]), .m_dstE(m_dstE[1]),
    .m_dstM(m_dstM[1]), .m_busy(m_busy[1])
  );

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [2:0]  exp_stat;
    bit          qual;
    logic [63:0] exp_valm;
  } vec_t;

  typedef struct {
    string       name;
    int          cyc;
    logic        busy;
    logic [2:0]  stat;
    logic [63:0] valm;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input int s,
    input logic [3:0] ic,
    input logic [2:0] st,
    input logic [63:0] ve,
    input logic [63:0] va
  );
    M_icode[s] = ic;
    M_stat[s]  = st;
    M_valE[s]  = ve;
    M_valA[s]  = va;
  endtask

  task automatic run(input int s, input vec_t v);
    int   lat;
    int   n;
    exp_t e;
    lat = (s == 0) ? LAT0 : LAT1;
    n = v.qual ? lat + 1 : 1;
    drive(s, v.icode, v.stat, v.vale, v.vala);
    for (int c = 0; c < n; c++)
      sb.push_back('{v.name, c,
        v.qual && (c < lat), v.exp_stat,
        (c == n - 1) ? v.exp_valm : 64'h0});
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s.busy[%0d]", e.name, e.cyc),
            64'(m_busy[s]), 64'(e.busy));
      check($sformatf("%s.stat[%0d]", e.name, e.cyc),
            64'(m_stat[s]), 64'(e.stat));
      check($sformatf("%s.valM[%0d]", e.name, e.cyc),
            m_valM[s], e.valm);
      if (c == 0) begin
        check($sformatf("%s.icode", e.name),
              64'(m_icode[s]), 64'(v.icode));
        check($sformatf("%s.valE", e.name),
              m_valE[s], v.vale);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    M_Cnd  = 1'b0;
    M_dstE = 4'h3;
    M_dstM = RNONE;
    drive(1, INOP, SAOK, 64'h0, 64'h0);
    drive(0, IMRMOVQ, SAOK, 64'h40, 64'h0);

    vt.push_back('{"wr40",  IRMMOVQ, SAOK, 64'h40, 64'hDEADBEEF, SAOK, 1, 64'h0});
    vt.push_back('{"rd40",  IMRMOVQ, SAOK, 64'h40, 64'h0, SAOK, 1, 64'hDEADBEEF});
    vt.push_back('{"rdoob", IMRMOVQ, SAOK, 64'h10000, 64'h0, SADR, 0, 64'h0});
    vt.push_back('{"wrmis", IRMMOVQ, SAOK, 64'h43, 64'h55, SADR, 0, 64'h0});
    vt.push_back('{"rd40b", IMRMOVQ, SAOK, 64'h40, 64'h0, SAOK, 1, 64'hDEADBEEF});
    vt.push_back('{"wr80",  IRMMOVQ, SAOK, 64'h80, 64'h1234, SAOK, 1, 64'h0});
    vt.push_back('{"pushs", IPUSHQ, SINS, 64'h80, 64'h5, SINS, 0, 64'h0});
    vt.push_back('{"rd80",  IMRMOVQ, SAOK, 64'h80, 64'h0, SAOK, 1, 64'h1234});
    vt.push_back('{"wr20",  IRMMOVQ, SAOK, 64'h20, 64'h11, SAOK, 1, 64'h0});
    vt.push_back('{"opq",   IOPQ, SAOK, 64'h43, 64'h1, SAOK, 0, 64'h0});
    vt.push_back('{"irmov", IIRMOVQ, SAOK, 64'h10000, 64'h0, SAOK, 0, 64'h0});
    vt.push_back('{"popq",  IPOPQ, SAOK, 64'h48, 64'h40, SAOK, 1, 64'hDEADBEEF});
    vt.push_back('{"nop",   INOP, SAOK, 64'h0, 64'h0, SAOK, 0, 64'h0});
    vt.push_back('{"wrtop", IRMMOVQ, SAOK, 64'hFFF8, 64'hA5, SAOK, 1, 64'h0});
    vt.push_back('{"rdtop", IMRMOVQ, SAOK, 64'hFFF8, 64'h0, SAOK, 1, 64'hA5});
    vt.push_back('{"call",  ICALL, SAOK, 64'h88, 64'h77, SAOK, 1, 64'h0});
    vt.push_back('{"rd88",  IMRMOVQ, SAOK, 64'h88, 64'h0, SAOK, 1, 64'h77});
    vt.push_back('{"ret",   IRET, SAOK, 64'h10000, 64'h40, SAOK, 1, 64'hDEADBEEF});
    vt.push_back('{"rdhlt", IMRMOVQ, SHLT, 64'h40, 64'h0, SHLT, 0, 64'h0});

    // Outputs under reset with a would-be qualified read present
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst.busy", 64'(m_busy[0]), 64'h0);
    check("rst.valM", m_valM[0], 64'h0);
    check("rst.stat", 64'(m_stat[0]), 64'(SAOK));
    check("rst.dstE", 64'(m_dstE[0]), 64'h3);
    check("rst.dstM", 64'(m_dstM[0]), 64'(RNONE));
    @(posedge clk);
    #1;
    drive(0, INOP, SAOK, 64'h0, 64'h0);
    rst_n = 1'b1;

    foreach (vt[i]) run(0, vt[i]);

    // Reset lands on the commit edge of a write to 0x20
    drive(0, IRMMOVQ, SAOK, 64'h20, 64'h7);
    @(negedge clk);
    check("abort.busy0", 64'(m_busy[0]), 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.busy_rst", 64'(m_busy[0]), 64'h0);
    check("abort.valM_rst", m_valM[0], 64'h0);
    check("abort.stat_rst", 64'(m_stat[0]), 64'(SAOK));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, INOP, SAOK, 64'h0, 64'h0);
    @(negedge clk);
    check("abort.busy_after", 64'(m_busy[0]), 64'h0);
    @(posedge clk);
    #1;
    run(0, '{"rd20", IMRMOVQ, SAOK, 64'h20, 64'h0, SAOK, 1, 64'h11});

    // No alignment check, single-cycle latency
    run(1, '{"na.wr43", IRMMOVQ, SAOK, 64'h43, 64'h99, SAOK, 1, 64'h0});
    run(1, '{"na.rd40", IMRMOVQ, SAOK, 64'h40, 64'h0, SAOK, 1, 64'h99});
    run(1, '{"na.pop47", IPOPQ, SAOK, 64'h0, 64'h47, SAOK, 1, 64'h99});
    run(1, '{"na.rdoob", IMRMOVQ, SAOK, 64'h10001, 64'h0, SADR, 0, 64'h0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
